pipeline_ctrl: RTL

- Central sequencer for the 5-stage pipeline registers: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Generates each register's write enable (xxW) and synchronous flush (xxRST), plus the PC enable and the data-memory request strobes.
- Resolves instruction/data memory wait, load-use stalls, branch/jump flushes and halt.
- Holds the data-memory load word when dhit arrives before ihit, so the MEM/WB register captures the correct value.

---
 rtl/pipeline_ctrl.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
// Handles memory wait, load-use stalls, branch flushes and halt. It also holds a load word that
// arrives before the instruction fetch completes.
// Optional feature macro: PIPE_PERF_EN adds saturating stall/flush performance counters.
module pipeline_ctrl #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic [31:0]      dmemload,
   input  logic             memcuDRE,
   input  logic             memcuDWE,
   input  logic             memcuHALT,
   input  logic             exMemToReg,
   input  logic [4:0]       exwsel,
   input  logic [4:0]       idrs,
   input  logic [4:0]       idrt,
   input  logic             branch_taken,
   output logic             pcW,
   output logic             ifidW,
   output logic             idexW,
   output logic             exmemW,
   output logic             memwbW,
   output logic             ifidRST,
   output logic             idexRST,
   output logic             exmemRST,
   output logic             memwbRST,
   output logic             dREN,
   output logic             dWEN,
   output logic [31:0]      memdmemload,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {StRun, StDWait, StDDone, StHalted} stateT;

   stateT       stateQ, stateD;
   logic [31:0] holdQ, holdD;
   logic        haltQ, haltD;
   logic        access, dok, adv, loadUse;

   assign access  = memcuDRE | memcuDWE;
   assign loadUse = exMemToReg & (exwsel != 5'd0) & ((exwsel == idrs) | (exwsel == idrt));
   assign halt    = haltQ;

   // State, held load word and sticky halt; reset aborts any outstanding access
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stateQ <= StRun;
         holdQ  <= 32'd0;
         haltQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         holdQ  <= holdD;
         haltQ  <= haltD;
      end
   end

   // Next state, data-side handshake, pipeline enables/flushes; outputs forced low in reset
   always_comb begin
      stateD      = stateQ;
      holdD       = holdQ;
      haltD       = haltQ;
      dok         = 1'b0;
      memdmemload = dmemload;
      pcW         = 1'b0;
      ifidW       = 1'b0;
      idexW       = 1'b0;
      exmemW      = 1'b0;
      memwbW      = 1'b0;
      ifidRST     = 1'b0;
      idexRST     = 1'b0;
      exmemRST    = 1'b0;
      memwbRST    = 1'b0;
      dREN        = 1'b0;
      dWEN        = 1'b0;

      unique case (stateQ)
         StRun: begin
            // Request is driven the cycle it appears; completion can only come in DWAIT
            dREN = memcuDRE;
            dWEN = memcuDWE;
            dok  = ~access;
            if (access) stateD = StDWait;
         end
         StDWait: begin
            dREN = memcuDRE;
            dWEN = memcuDWE;
            dok  = dhit;
            if (dhit && ihit) begin
               stateD = StRun;
            end else if (dhit) begin
               holdD  = dmemload;
               stateD = StDDone;
            end
         end
         StDDone: begin
            dok         = 1'b1;
            memdmemload = holdQ;
            if (ihit) stateD = StRun;
         end
         default: ;
      endcase

      adv = ihit & dok & (stateQ != StHalted);

      if (adv && memcuHALT) begin
         // Final cycle: only the instruction already in MEM retires
         memwbW = 1'b1;
         haltD  = 1'b1;
         stateD = StHalted;
      end else if (adv) begin
         pcW    = 1'b1;
         ifidW  = 1'b1;
         idexW  = 1'b1;
         exmemW = 1'b1;
         memwbW = 1'b1;
         if (branch_taken) begin
            // Squashes the load-use victim too, so no stall is needed
            ifidRST = 1'b1;
            idexRST = 1'b1;
         end else if (loadUse) begin
            pcW     = 1'b0;
            ifidW   = 1'b0;
            idexRST = 1'b1;
         end
      end

      if (!nRST) begin
         pcW    = 1'b0;
         ifidW  = 1'b0;
         idexW  = 1'b0;
         exmemW = 1'b0;
         memwbW = 1'b0;
         ifidRST  = 1'b0;
         idexRST  = 1'b0;
         exmemRST = 1'b0;
         memwbRST = 1'b0;
         dREN   = 1'b0;
         dWEN   = 1'b0;
      end
   end

`ifdef PIPE_PERF_EN
   logic [CNT_W-1:0] stallQ, flushQ;
   logic             stallInc, flushInc;

   assign stallInc  = (~adv & (stateQ != StHalted)) | (adv & ~memcuHALT & ~branch_taken & loadUse);
   assign flushInc  = adv & ~memcuHALT & branch_taken;
   assign stall_cnt = stallQ;
   assign flush_cnt = flushQ;

   // Saturating performance counters
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stallQ <= '0;
         flushQ <= '0;
      end else begin
         if (stallInc && (stallQ != '1)) stallQ <= stallQ + CNT_W'(1);
         if (flushInc && (flushQ != '1)) flushQ <= flushQ + CNT_W'(1);
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
